// File: rtl/vwb_queue.sv
// Writeback request queue: DEPTH-entry FIFO feeding the register-select decoder.
// Define VWB_QUEUE_SCOREBOARD_EN to build the per-entry group masks behind `pending`.
module vwb_queue #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_sel,
    input  logic [2:0]                 in_vlmul,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       wb_stall,
    output logic                       wb_load,
    output logic [4:0]                 wb_sel,
    output logic [2:0]                 vlmul,
    output logic [DATA_W-1:0]          wb_data,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full_q, full_d;
    logic              err_q, err_d;

    logic [4:0]        sel_mem   [DEPTH];
    logic [2:0]        vlmul_mem [DEPTH];
    logic [DATA_W-1:0] data_mem  [DEPTH];

    logic push, pop, not_empty;

    assign not_empty = (count_q != '0);
    assign in_ready  = rst_n & ~full_q & ~flush;
    assign push      = in_valid & in_ready;
    assign pop       = not_empty & ~wb_stall;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        err_d   = err_q | (push & in_vlmul[2]);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + PW'(1);
            if (pop)  head_d = head_q + PW'(1);
            count_d = count_q + CW'(push) - CW'(pop);
        end
        full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            full_q  <= full_d;
            err_q   <= err_d;
        end
    end

    // Payload storage needs no reset: outputs are gated by occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            sel_mem[tail_q]   <= in_sel;
            vlmul_mem[tail_q] <= in_vlmul;
            data_mem[tail_q]  <= in_data;
        end
    end

    assign wb_sel  = not_empty ? sel_mem[head_q]   : '0;
    assign vlmul   = not_empty ? vlmul_mem[head_q] : '0;
    assign wb_data = not_empty ? data_mem[head_q]  : '0;
    assign wb_load = pop & ~vlmul_mem[head_q][2];
    assign count   = count_q;
    assign err     = err_q;

`ifdef VWB_QUEUE_SCOREBOARD_EN
    logic [31:0] mask_mem [DEPTH];

    // Group base is in_sel aligned down to the group size; illegal codes give no mask.
    function automatic logic [31:0] group_mask(input logic [4:0] sel, input logic [2:0] lm);
        logic [4:0]  n;
        logic [4:0]  base;
        logic [31:0] ones;
        n    = 5'd1 << lm[1:0];
        base = sel & ~(n - 5'd1);
        ones = (32'd1 << n) - 32'd1;
        return lm[2] ? '0 : (ones << base);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mask_mem[tail_q] <= group_mask(in_sel, in_vlmul);
    end

    // A slot is live when its distance from head is below the occupancy.
    always_comb begin : pend_or
        logic [PW-1:0] off;
        off     = '0;
        pending = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            off = PW'(i) - head_q;
            if ({1'b0, off} < count_q) pending = pending | mask_mem[i];
        end
    end
`else
    assign pending = '0;
`endif

endmodule

// File: tb/tb_vwb_queue.sv
// Randomized bench for vwb_queue against a queue-based reference model.
module tb_vwb_queue;

    localparam int unsigned DATA_W = 256;
    localparam int unsigned DEPTH  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_sel;
    logic [2:0]        in_vlmul;
    logic [DATA_W-1:0] in_data;
    logic              wb_stall;
    logic              wb_load;
    logic [4:0]        wb_sel;
    logic [2:0]        vlmul;
    logic [DATA_W-1:0] wb_data;
    logic [31:0]       pending;
    logic [2:0]        count;
    logic              err;

    vwb_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_sel(in_sel), .in_vlmul(in_vlmul), .in_data(in_data), .wb_stall(wb_stall),
        .wb_load(wb_load), .wb_sel(wb_sel), .vlmul(vlmul), .wb_data(wb_data),
        .pending(pending), .count(count), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        sel;
        logic [2:0]        lm;
        logic [DATA_W-1:0] data;
    } ent_t;

    ent_t q[$];
    logic m_err = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_mask(input logic [4:0] s, input logic [2:0] lm);
        int n, base;
        logic [31:0] m;
        m = '0;
        if (lm >= 3'd4) return m;
        n    = 1 << lm;
        base = (int'(s) / n) * n;
        for (int b = 0; b < 32; b++)
            if (b >= base && b < base + n) m[b] = 1'b1;
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] d;
        for (int k = 0; k < DATA_W / 32; k++) d[k*32 +: 32] = $urandom;
        return d;
    endfunction

    // One clock: drive, check at negedge against the model, then advance the model.
    task automatic cyc(input logic v, input logic [4:0] s, input logic [2:0] lm,
                       input logic [DATA_W-1:0] d, input logic st, input logic fl, input logic rn);
        logic        e_ready, e_load, ne, do_pop, do_push;
        logic [31:0] e_pend;
        ent_t        h, e;
        in_valid = v; in_sel = s; in_vlmul = lm; in_data = d;
        wb_stall = st; flush = fl; rst_n = rn;
        @(negedge clk);
        ne      = (q.size() != 0);
        e_ready = rn && (q.size() < DEPTH) && !fl;
        check("in_ready", DATA_W'(in_ready), DATA_W'(e_ready));
        if (rn) begin
            h      = ne ? q[0] : '{sel: 5'd0, lm: 3'd0, data: '0};
            e_load = ne && !st && !h.lm[2];
            e_pend = '0;
`ifdef VWB_QUEUE_SCOREBOARD_EN
            foreach (q[k]) e_pend |= ref_mask(q[k].sel, q[k].lm);
`endif
            check("wb_load", DATA_W'(wb_load), DATA_W'(e_load));
            check("wb_sel",  DATA_W'(wb_sel),  DATA_W'(h.sel));
            check("vlmul",   DATA_W'(vlmul),   DATA_W'(h.lm));
            check("wb_data", wb_data,          h.data);
            check("pending", DATA_W'(pending), DATA_W'(e_pend));
            check("count",   DATA_W'(count),   DATA_W'(q.size()));
            check("err",     DATA_W'(err),     DATA_W'(m_err));
        end
        if (!rn) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            do_pop  = ne && !st;
            do_push = v && e_ready;
            if (do_push && lm[2]) m_err = 1'b1;
            if (fl) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) begin
                    e.sel = s; e.lm = lm; e.data = d;
                    q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic st);
        cyc(1'b0, 5'd0, 3'd0, '0, st, 1'b0, 1'b1);
    endtask

    task automatic push(input logic [4:0] s, input logic [2:0] lm, input logic st);
        cyc(1'b1, s, lm, rand_data(), st, 1'b0, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = '0;
        in_vlmul = '0; in_data = '0; wb_stall = 1'b0;
        cyc(1'b0, 5'd0, 3'd0, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 5'd0, 3'd0, '0, 1'b0, 1'b0, 1'b0);

        // single push, next-cycle writeback
        cyc(1'b1, 5'd3, 3'd0, DATA_W'(8'hA5), 1'b0, 1'b0, 1'b1);
        idle(1'b0);
        idle(1'b0);

        // grouped pending under stall, then drain
        push(5'd5, 3'd2, 1'b1);
        push(5'd16, 3'd3, 1'b1);
        idle(1'b1);
        idle(1'b0);
        idle(1'b0);
        idle(1'b0);

        // fill, simultaneous push/pop at full, wrap
        for (int i = 0; i < 4; i++) push(5'(i * 3), 3'(i % 4), 1'b1);
        push(5'd9, 3'd0, 1'b1);
        push(5'd10, 3'd1, 1'b0);
        push(5'd11, 3'd0, 1'b0);
        for (int i = 0; i < 6; i++) push(5'(20 + i), 3'(i % 3), 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b0);

        // illegal vlmul
        push(5'd2, 3'd4, 1'b0);
        idle(1'b0);
        idle(1'b0);

        // flush with in_valid, then reset with entries queued
        for (int i = 0; i < 3; i++) push(5'(i + 7), 3'd0, 1'b1);
        cyc(1'b1, 5'd1, 3'd0, rand_data(), 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        push(5'd8, 3'd3, 1'b1);
        push(5'd12, 3'd2, 1'b1);
        cyc(1'b1, 5'd4, 3'd0, rand_data(), 1'b1, 1'b0, 1'b0);
        idle(1'b0);

        for (int i = 0; i < 3000; i++) begin
            logic [2:0] lm;
            lm = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            cyc($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), lm, rand_data(),
                $urandom_range(0, 9) < 3, $urandom_range(0, 39) == 0,
                $urandom_range(0, 99) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
